// File: rtl/period_meter.sv
// period_meter: measures the interval, in clk cycles, between successive
// single-cycle tick pulses while enable is high.
//
// Optional feature: define PERIOD_METER_LOCK_EN to build the lock detector,
// which raises 'locked' when two consecutive measured periods are equal.
// Without the macro 'locked' is tied low and no history/compare logic exists.
//
// The counter saturates at its maximum; an interval longer than that raises
// the sticky 'overflow' flag and parks the FSM in OVF until the next tick,
// which only restarts measurement (the overflowed interval is never reported).
module period_meter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         enable,
    input  logic         tick,
    input  logic         clr,
    output logic [N-1:0] period,
    output logic         period_vld,
    output logic         overflow,
    output logic         locked
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        OVF  = 2'd2
    } state_t;

    state_t       state_reg;
    state_t       state_next;

    logic [N-1:0] cnt_reg;
    logic [N-1:0] cnt_next;
    logic [N-1:0] period_reg;
    logic [N-1:0] period_next;
    logic         period_vld_reg;
    logic         period_vld_next;
    logic         overflow_reg;
    logic         overflow_next;

    // A tick that closes a valid interval: the only event that updates period.
    logic         measure_done;
    // An enabled cycle without tick while the count is already saturated.
    logic         count_exhausted;

    assign measure_done    = enable && tick && (state_reg == MEAS);
    assign count_exhausted = enable && !tick && (state_reg == MEAS) && (cnt_reg == CNT_MAX);

    // State register: asynchronous reset returns to IDLE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: clr dominates, then nothing moves unless enable is high.
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else if (enable) begin
            unique case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_next = MEAS;
                    end
                end
                MEAS: begin
                    if (count_exhausted) begin
                        state_next = OVF;
                    end
                end
                OVF: begin
                    if (tick) begin
                        state_next = MEAS;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath next values: interval counter, reported period, pulse and flag.
    always_comb begin
        cnt_next        = cnt_reg;
        period_next     = period_reg;
        period_vld_next = 1'b0;
        overflow_next   = overflow_reg;
        if (clr) begin
            cnt_next      = '0;
            period_next   = '0;
            overflow_next = 1'b0;
        end else if (enable) begin
            unique case (state_reg)
                IDLE: begin
                    if (tick) begin
                        cnt_next = CNT_ONE;
                    end
                end
                MEAS: begin
                    if (tick) begin
                        period_next     = cnt_reg;
                        period_vld_next = 1'b1;
                        cnt_next        = CNT_ONE;
                    end else if (cnt_reg == CNT_MAX) begin
                        // Saturate rather than wrap; the interval is lost.
                        overflow_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                OVF: begin
                    // Restart counting only; the old period stays visible.
                    if (tick) begin
                        cnt_next = CNT_ONE;
                    end
                end
                default: begin
                    cnt_next = '0;
                end
            endcase
        end
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_reg        <= '0;
            period_reg     <= '0;
            period_vld_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            period_reg     <= period_next;
            period_vld_reg <= period_vld_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign period     = period_reg;
    assign period_vld = period_vld_reg;
    assign overflow   = overflow_reg;

`ifdef PERIOD_METER_LOCK_EN
    // have_prev_reg marks that period_reg holds a real measurement made since
    // the last return to IDLE, so the reset value 0 is never compared against.
    logic have_prev_reg;
    logic have_prev_next;
    logic locked_reg;
    logic locked_next;

    // Lock decision: compare each new period with the one it replaces.
    always_comb begin
        have_prev_next = have_prev_reg;
        locked_next    = locked_reg;
        if (clr) begin
            have_prev_next = 1'b0;
            locked_next    = 1'b0;
        end else if (measure_done) begin
            locked_next    = have_prev_reg && (cnt_reg == period_reg);
            have_prev_next = 1'b1;
        end else if (count_exhausted) begin
            locked_next = 1'b0;
        end
    end

    // Lock history registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            have_prev_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            have_prev_reg <= have_prev_next;
            locked_reg    <= locked_next;
        end
    end

    assign locked = locked_reg;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter (N=4). Stimulus drives inputs on the falling
// edge and updates a timestamp-based reference model; every expected period
// report is queued and a separate monitor pops it when period_vld appears.
module tb_period_meter;

    localparam int N   = 4;
    localparam int MAX = (1 << N) - 1;
`ifdef PERIOD_METER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk;
    logic         n_reset;
    logic         enable;
    logic         tick;
    logic         clr;
    logic [N-1:0] period;
    logic         period_vld;
    logic         overflow;
    logic         locked;

    period_meter #(.N(N)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .enable     (enable),
        .tick       (tick),
        .clr        (clr),
        .period     (period),
        .period_vld (period_vld),
        .overflow   (overflow),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        bit locked;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int vld_seen = 0;

    // Reference model: time is counted in enabled clock edges only.
    int k;          // index of the current enabled edge
    bit started;    // a first tick has been seen since IDLE
    bit in_ovf;     // current interval already exceeded the maximum
    int last_tick;  // enabled-edge index of the last accepted tick
    int m_period;
    bit m_ovf;
    bit m_locked;
    bit m_have_prev;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        started = 0; in_ovf = 0; m_period = 0; m_ovf = 0;
        m_locked = 0; m_have_prev = 0;
    endtask

    task automatic model_edge(input bit en, input bit tk, input bit cl);
        exp_t e;
        int   intv;
        if (cl) begin
            model_clear();
        end else if (en) begin
            k++;
            if (tk) begin
                if (started && !in_ovf) begin
                    intv     = k - last_tick;
                    e.period = intv;
                    e.locked = LOCK && m_have_prev && (intv == m_period);
                    sb.push_back(e);
                    m_period    = intv;
                    m_locked    = e.locked;
                    m_have_prev = 1;
                end
                started   = 1;
                in_ovf    = 0;
                last_tick = k;
            end else if (started && !in_ovf && (k - last_tick) >= MAX) begin
                // No tick on this edge: the interval must exceed MAX.
                in_ovf   = 1;
                m_ovf    = 1;
                m_locked = 0;
            end
        end
    endtask

    // One clock: check steady outputs against the model, then drive inputs.
    task automatic step(input bit en, input bit tk, input bit cl);
        @(negedge clk);
        chk("period", int'(period), m_period);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("locked", int'(locked), int'(m_locked));
        enable = en;
        tick   = tk;
        clr    = cl;
        model_edge(en, tk, cl);
    endtask

    task automatic ticks_every(input int t, input int count);
        for (int c = 0; c < count; c++) begin
            step(1, 1, 0);
            for (int j = 1; j < t; j++) step(1, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1, 0, 0);
    endtask

    // Monitor: every period_vld pulse must match the oldest queued report.
    always @(negedge clk) begin
        exp_t e;
        if (n_reset && period_vld) begin
            vld_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_vld", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("vld_period", int'(period), e.period);
                chk("vld_locked", int'(locked), int'(e.locked));
                $display("[TB] period_vld period=%0d locked=%0d overflow=%0d", period, locked, overflow);
            end
        end
    end

    initial begin
        int v0;
        int seg_p;
        n_reset = 1'b0; enable = 1'b0; tick = 1'b0; clr = 1'b0;
        k = 0; last_tick = 0;
        model_clear();
        #12;
        chk("rst_period", int'(period), 0);
        chk("rst_vld", int'(period_vld), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_locked", int'(locked), 0);
        @(negedge clk);
        n_reset = 1'b1;

        // Ticks every 5 cycles, four of them: three reports of 5.
        v0 = vld_seen;
        ticks_every(5, 4);
        idle(2);
        chk("req28_pulses", vld_seen - v0, 3);
        chk("req28_period", int'(period), 5);
        chk("req28_locked", int'(locked), int'(LOCK));

        // Intervals 5 then 7.
        step(1, 0, 1);
        step(1, 1, 0); idle(4); step(1, 1, 0); idle(6); step(1, 1, 0); idle(2);
        chk("req29_period", int'(period), 7);
        chk("req29_locked", int'(locked), 0);

        // Overflow, restart without report, then interval 3.
        step(1, 0, 1);
        step(1, 1, 0); idle(16);
        chk("req30_overflow", int'(overflow), 1);
        v0 = vld_seen;
        step(1, 1, 0); idle(2); step(1, 1, 0); idle(2);
        chk("req30_pulses", vld_seen - v0, 1);
        chk("req30_period", int'(period), 3);
        chk("req30_overflow_sticky", int'(overflow), 1);

        // Interval exactly 15, then an interval paused by enable=0 with ticks.
        step(1, 0, 1);
        step(1, 1, 0); idle(14); step(1, 1, 0);
        idle(3);
        for (int j = 0; j < 4; j++) step(0, 1, 0);
        idle(1); step(1, 1, 0); idle(2);
        chk("req31_period", int'(period), 5);
        chk("req31_overflow", int'(overflow), 0);

        // Tick every cycle.
        step(1, 0, 1);
        for (int j = 0; j < 5; j++) step(1, 1, 0);
        idle(1);
        chk("t1_period", int'(period), 1);

        // clr together with tick.
        step(1, 1, 0); idle(2);
        v0 = vld_seen;
        step(1, 1, 1); idle(2);
        chk("req32_clr_vld", vld_seen - v0, 0);

        // Asynchronous reset mid-interval.
        step(1, 1, 0); idle(3);
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        chk("async_period", int'(period), 0);
        chk("async_vld", int'(period_vld), 0);
        chk("async_overflow", int'(overflow), 0);
        chk("async_locked", int'(locked), 0);
        sb.delete();
        model_clear();
        enable = 1'b0; tick = 1'b0; clr = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        v0 = vld_seen;
        step(1, 1, 0); idle(3);
        chk("req32_first_tick", vld_seen - v0, 0);
        step(1, 1, 0); idle(1);
        chk("req32_period", int'(period), 4);

        // Randomized segments with varying tick density.
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 3))
                0: seg_p = 2;
                1: seg_p = 6;
                2: seg_p = 12;
                default: seg_p = 24;
            endcase
            for (int j = 0; j < 40; j++) begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(1, seg_p) == 1,
                     $urandom_range(0, 99) < 2);
            end
        end

        for (int j = 0; j < 3; j++) step(0, 0, 0);
        chk("queue_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
